// File: rtl/localbus_stat_pkg.sv
// rtl/localbus_stat_pkg.sv - shared encodings and address map for the localbus statistics slave
package localbus_stat_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CS  = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam int REGION_BIT = 8;
  localparam int IDX_MSB    = 5;
  localparam int IDX_LSB    = 0;
  localparam int IDX_W      = IDX_MSB - IDX_LSB + 1;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam logic [1:0] OFF_CTRL = 2'd0;
  localparam logic [1:0] OFF_ID   = 2'd1;

  localparam logic [31:0] ID_VALUE = 32'h5354_4154;

  // clr_all is self-clearing, so only cnt_en is ever visible on a CTRL read
  function automatic logic [31:0] ctrl_word(input logic en);
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT] = en;
  endfunction

endpackage

// File: rtl/stat_counter.sv
// rtl/stat_counter.sv - one saturating event counter with clear and read-to-clear
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             en,
  input  logic             clr,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic bump;
  assign bump = inc & en;

  // clear wins; a read-to-clear keeps a same-cycle event; otherwise count up and stick at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (rd_clr)
      count <= bump ? ONE : '0;
    else if (bump && count != MAX)
      count <= count + ONE;
  end

endmodule

// File: rtl/localbus_stat_slave.sv
// rtl/localbus_stat_slave.sv - localbus slave exposing statistics counters and CTRL/ID registers (option: LOCALBUS_STAT_RD_CLR_EN)
module localbus_stat_slave
  import localbus_stat_pkg::*;
#(
  parameter int CNT_NUM = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs_n,
  input  logic               rd_wr,
  input  logic [31:0]        data,
  input  logic               ale,
  output logic               ack_n,
  output logic [31:0]        data_out,
  input  logic [CNT_NUM-1:0] cnt_inc,
  input  logic               cnt_clr
);

  state_t             state, next_state;
  logic [31:0]        addr;
  logic               cnt_en;
  logic               access, do_rd, do_wr, wr_ctrl, clr_all;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt_q [CNT_NUM];
  logic [CNT_NUM-1:0] rd_clr;
  logic [31:0]        rd_cnt, rd_val;
  logic               unused_addr;

  assign idx         = addr[IDX_MSB:IDX_LSB];
  assign unused_addr = ^{addr[31:REGION_BIT+1], addr[REGION_BIT-1:IDX_MSB+1]};

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // next state: latch address, wait for chip select, wait for release
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (ale)   next_state = WAIT_CS;
      WAIT_CS:  if (!cs_n) next_state = WAIT_REL;
      WAIT_REL: if (cs_n)  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // access decode for the single cycle in which cs_n is sampled low in WAIT_CS
  always_comb begin
    access  = (state == WAIT_CS) && !cs_n;
    do_rd   = access && rd_wr;
    do_wr   = access && !rd_wr;
    wr_ctrl = do_wr && addr[REGION_BIT] && (addr[1:0] == OFF_CTRL);
    clr_all = wr_ctrl && data[CTRL_CLR_BIT];
  end

  // counter select; out-of-range indices match nothing and read as zero
  always_comb begin
    rd_cnt = '0;
    rd_clr = '0;
    for (int i = 0; i < CNT_NUM; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_cnt = 32'(cnt_q[i]);
`ifdef LOCALBUS_STAT_RD_CLR_EN
        rd_clr[i] = do_rd && !addr[REGION_BIT];
`endif
      end
    end
  end

  // read data mux across counter and control regions
  always_comb begin
    rd_val = '0;
    if (addr[REGION_BIT]) begin
      case (addr[1:0])
        OFF_CTRL: rd_val = ctrl_word(cnt_en);
        OFF_ID:   rd_val = ID_VALUE;
        default:  rd_val = '0;
      endcase
    end else begin
      rd_val = rd_cnt;
    end
  end

  // registered bus outputs, latched address and CTRL enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      ack_n    <= 1'b1;
      data_out <= '0;
      cnt_en   <= 1'b1;
    end else begin
      if (state == IDLE && ale)
        addr <= data;
      ack_n <= (next_state != WAIT_REL);
      if (do_rd)
        data_out <= rd_val;
      if (wr_ctrl)
        cnt_en <= data[CTRL_EN_BIT];
    end
  end

  for (genvar g = 0; g < CNT_NUM; g++) begin : g_cnt
    stat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (cnt_inc[g]),
      .en     (cnt_en),
      .clr    (cnt_clr | clr_all),
      .rd_clr (rd_clr[g]),
      .count  (cnt_q[g])
    );
  end

endmodule

// File: tb/tb_localbus_stat_slave.sv
// tb/tb_localbus_stat_slave.sv - scoreboard bench for localbus_stat_slave with a behavioural counter model
module tb_localbus_stat_slave;

  localparam int N   = 16;
  localparam int W   = 4;
  localparam int MAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs_n = 1'b1;
  logic          rd_wr = 1'b0;
  logic [31:0]   data = '0;
  logic          ale = 1'b0;
  logic          ack_n;
  logic [31:0]   data_out;
  logic [N-1:0]  cnt_inc = '0;
  logic          cnt_clr = 1'b0;

  localbus_stat_slave #(.CNT_NUM(N), .CNT_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .rd_wr    (rd_wr),
    .data     (data),
    .ale      (ale),
    .ack_n    (ack_n),
    .data_out (data_out),
    .cnt_inc  (cnt_inc),
    .cnt_clr  (cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  int          m_cnt [N];
  bit          m_en = 1'b1;
  bit          m_wr_ctrl = 1'b0;
  logic [31:0] m_wr_data = '0;
  int          m_rd_idx = -1;
  bit          rand_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_en = 1'b1;
  endtask

  // what the host must read back for address a, given the model state before this edge
  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int k;
    k = int'(a[5:0]);
    if (a[8]) begin
      if (a[1:0] == 2'd0) return {31'd0, m_en};
      if (a[1:0] == 2'd1) return 32'h5354_4154;
      return 32'd0;
    end
    if (k < N) return 32'(m_cnt[k]);
    return 32'd0;
  endfunction

  // apply one clock edge to the model using the inputs presented this cycle
  task automatic model_update();
    bit clr;
    clr = cnt_clr || (m_wr_ctrl && m_wr_data[1]);
    for (int i = 0; i < N; i++) begin
      if (clr)
        m_cnt[i] = 0;
`ifdef LOCALBUS_STAT_RD_CLR_EN
      else if (i == m_rd_idx)
        m_cnt[i] = (cnt_inc[i] && m_en) ? 1 : 0;
`endif
      else if (cnt_inc[i] && m_en && m_cnt[i] < MAX)
        m_cnt[i] = m_cnt[i] + 1;
    end
    if (m_wr_ctrl) m_en = m_wr_data[0];
  endtask

  task automatic cyc();
    if (rand_mode) begin
      cnt_inc = N'($urandom & $urandom & $urandom);
      cnt_clr = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic bus_xfer(input logic [31:0] a, input bit rd, input logic [31:0] wdata,
                          input logic [N-1:0] acc_inc);
    // address phase, sometimes with cs_n already low (access must wait a cycle)
    ale   = 1'b1;
    data  = a;
    cs_n  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
    rd_wr = rd;
    if (!rand_mode) cnt_inc = '0;
    cyc();
    ale  = 1'b0;
    cs_n = 1'b1;
    // a stray ale while waiting for chip select must not move the address
    if ($urandom_range(0, 2) == 0) begin
      ale  = 1'b1;
      data = $urandom;
      cyc();
      ale = 1'b0;
    end
    cs_n  = 1'b0;
    rd_wr = rd;
    data  = rd ? 32'($urandom) : wdata;
    if (rd) q.push_back('{1'b1, exp_read(a)});
    else    q.push_back('{1'b0, 32'd0});
    m_wr_ctrl = !rd && a[8] && (a[1:0] == 2'd0);
    m_wr_data = wdata;
    m_rd_idx  = (rd && !a[8] && int'(a[5:0]) < N) ? int'(a[5:0]) : -1;
    if (!rand_mode) cnt_inc = acc_inc;
    cyc();
    m_wr_ctrl = 1'b0;
    m_rd_idx  = -1;
    if (!rand_mode) cnt_inc = '0;
    chk("ack_assert", 32'(ack_n), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      ale  = 1'($urandom_range(0, 1));
      data = $urandom;
      cyc();
      chk("ack_hold", 32'(ack_n), 32'd0);
    end
    ale  = 1'b0;
    cs_n = 1'b1;
    cyc();
    chk("ack_release", 32'(ack_n), 32'd1);
  endtask

  // monitor: every falling edge of ack_n retires one scoreboard entry
  logic prev_ack = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && prev_ack === 1'b1 && ack_n === 1'b0) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: got ack_n=0 expected no transaction at %0t", $time);
      end else begin
        e = q.pop_front();
        if (e.is_rd) chk("read_data", data_out, e.val);
      end
    end
    prev_ack = ack_n;
  end

  initial begin
    logic [31:0] r, a;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ack_n", 32'(ack_n), 32'd1);
    chk("reset_data_out", data_out, 32'd0);
    reset = 1'b0;
    cyc();

    // basic read
    repeat (5) begin
      cnt_inc = N'(1 << 3); cyc();
      cnt_inc = '0;         cyc();
    end
    bus_xfer(32'h3, 1'b1, 32'd0, '0);

    // saturation
    repeat (20) begin cnt_inc = N'(1); cyc(); end
    cnt_inc = '0;
    bus_xfer(32'h0, 1'b1, 32'd0, '0);

    // control writes
    bus_xfer(32'h100, 1'b0, 32'd0, '0);
    repeat (3) begin cnt_inc = N'(1 << 1); cyc(); end
    cnt_inc = '0;
    bus_xfer(32'h1, 1'b1, 32'd0, '0);
    bus_xfer(32'h100, 1'b0, 32'd3, '0);
    bus_xfer(32'h100, 1'b1, 32'd0, '0);
    bus_xfer(32'h0, 1'b1, 32'd0, '0);
    bus_xfer(32'h3, 1'b1, 32'd0, '0);

    // clear/increment collision
    repeat (2) begin cnt_inc = N'(1 << 2); cyc(); end
    cnt_inc = N'(1 << 2);
    cnt_clr = 1'b1;
    cyc();
    cnt_inc = '0;
    cnt_clr = 1'b0;
    bus_xfer(32'h2, 1'b1, 32'd0, '0);

    // side reads and ignored writes
    bus_xfer(32'h101, 1'b1, 32'd0, '0);
    bus_xfer(32'h14, 1'b1, 32'd0, '0);
    bus_xfer(32'h102, 1'b1, 32'd0, '0);
    bus_xfer(32'h103, 1'b1, 32'd0, '0);
    repeat (4) begin cnt_inc = N'(1 << 3); cyc(); end
    cnt_inc = '0;
    bus_xfer(32'h3, 1'b0, 32'hFFFF_FFFF, '0);
    bus_xfer(32'h101, 1'b0, 32'h0, '0);
    bus_xfer(32'h3, 1'b1, 32'd0, '0);
    bus_xfer(32'h101, 1'b1, 32'd0, '0);

    // read with an event in the acknowledge cycle
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    repeat (7) begin cnt_inc = N'(1 << 4); cyc(); end
    cnt_inc = '0;
    bus_xfer(32'h4, 1'b1, 32'd0, N'(1 << 4));
    bus_xfer(32'h4, 1'b1, 32'd0, '0);

    // reset in WAIT_REL
    repeat (3) begin cnt_inc = N'(1 << 3); cyc(); end
    cnt_inc = '0;
    ale = 1'b1; data = 32'h3; cyc();
    ale = 1'b0; cs_n = 1'b0; rd_wr = 1'b1;
    q.push_back('{1'b1, exp_read(32'h3)});
    m_rd_idx = 3;
    cyc();
    m_rd_idx = -1;
    chk("mid_ack_low", 32'(ack_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_ack_n", 32'(ack_n), 32'd1);
    chk("mid_reset_data_out", data_out, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cs_n  = 1'b1;
    cyc();
    bus_xfer(32'h3, 1'b1, 32'd0, '0);
    bus_xfer(32'h100, 1'b1, 32'd0, '0);

    // randomized traffic
    rand_mode = 1'b1;
    repeat (150) begin
      repeat ($urandom_range(0, 3)) cyc();
      r = $urandom;
      a = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: bus_xfer({a[31:9], 1'b0, a[7:6], 6'($urandom_range(0, 23))}, 1'b1, 32'd0, '0);
        3:       bus_xfer({a[31:9], 1'b1, a[7:0]}, 1'b1, 32'd0, '0);
        4:       bus_xfer({a[31:9], 1'b1, a[7:2], 2'd0}, 1'b0,
                          {r[31:2], r[1] & r[2], r[0] | r[3]}, '0);
        default: bus_xfer(a, 1'b0, r, '0);
      endcase
    end
    rand_mode = 1'b0;
    cnt_inc   = '0;
    cnt_clr   = 1'b0;
    repeat (3) cyc();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
